// File: rtl/memory_game_pkg.sv
// Shared types for the memory game: FSM states, play modes and LFSR taps.
package memory_game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EXTEND,
        SHOW_ON,
        SHOW_OFF,
        INPUT,
        OVER,
        WIN
    } state_t;

    typedef enum logic [1:0] {
        CLASSIC = 2'd0,
        TIMED   = 2'd1,
        REVERSE = 2'd2
    } mode_t;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Raw mode input to a game mode; the unused code 3 plays as classic.
    function automatic mode_t decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return TIMED;
            2'd2:    return REVERSE;
            default: return CLASSIC;
        endcase
    endfunction

endpackage

// File: rtl/game_lfsr.sv
// Free-running 16-bit Galois LFSR used as the pattern symbol source.
module game_lfsr
    import memory_game_pkg::*;
#(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 3
) (
    input  logic             clock,
    input  logic             rst_n,
    output logic [OUT_W-1:0] value
);

    logic [15:0] lfsr_q;

    // Shift right every cycle, folding the outgoing bit back in through the tap mask.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign value = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/memory_game_engine.sv
// Simon-style memory game: grows a random pattern, plays it back on the LEDs
// and checks the player's button presses in classic, timed or reverse mode.
module memory_game_engine
    import memory_game_pkg::*;
#(
    parameter int          N_BTN          = 8,
    parameter int          MAX_LEN        = 16,
    parameter int          SHOW_CYCLES    = 1000,
    parameter int          TIMEOUT_CYCLES = 5000,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                             clock,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [1:0]                       mode,
    input  logic [N_BTN-1:0]                 btn,
    output logic [N_BTN-1:0]                 led,
    output logic                             active,
    output logic                             over,
    output logic                             win,
    output logic [$clog2(MAX_LEN+1)-1:0]     score,
    output logic [$clog2(MAX_LEN+1)-1:0]     high_score
);

    localparam int SYM_W  = $clog2(N_BTN);
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMR_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int SHW_W  = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    state_t             state, state_nxt;
    mode_t              mode_q, mode_nxt;
    logic               start_prev;
    logic [N_BTN-1:0]   btn_prev;
    logic [LEN_W-1:0]   length, length_nxt;
    logic [LEN_W-1:0]   index, index_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic [SHW_W-1:0]   show_cnt, show_nxt;
    logic [LEN_W-1:0]   score_nxt, high_nxt;
    logic               pat_we;

    logic [SYM_W-1:0]   pattern [MAX_LEN];
    logic [SYM_W-1:0]   lfsr_sym;

    logic               start_edge;
    logic               btn_edge;
    logic [ADDR_W-1:0]  exp_addr;
    logic [SYM_W-1:0]   exp_sym;
    logic [SYM_W-1:0]   show_sym;
    logic               press_ok;
    logic               at_last;
    logic               show_done;

    game_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (SYM_W)
    ) u_lfsr (
        .clock (clock),
        .rst_n (rst_n),
        .value (lfsr_sym)
    );

    assign start_edge = start & ~start_prev;
    assign btn_edge   = |(btn & ~btn_prev);
    assign at_last    = (index == length - LEN_W'(1));
    assign show_done  = (show_cnt == SHW_W'(SHOW_CYCLES - 1));
    assign exp_addr   = (mode_q == REVERSE) ? ADDR_W'(length - index - LEN_W'(1))
                                            : index[ADDR_W-1:0];
    assign exp_sym    = pattern[exp_addr];
    assign show_sym   = pattern[index[ADDR_W-1:0]];
    assign press_ok   = (btn == (N_BTN'(1) << exp_sym));

    // State register; everything else in the game moves with it.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus the next values of every game counter.
    always_comb begin
        state_nxt  = state;
        mode_nxt   = mode_q;
        length_nxt = length;
        index_nxt  = index;
        timer_nxt  = timer;
        show_nxt   = show_cnt;
        score_nxt  = score;
        pat_we     = 1'b0;

        case (state)
            IDLE, OVER, WIN: begin
                if (start_edge) begin
                    mode_nxt   = decode_mode(mode);
                    length_nxt = '0;
                    score_nxt  = '0;
                    state_nxt  = EXTEND;
                end
            end

            EXTEND: begin
                pat_we     = 1'b1;
                length_nxt = length + LEN_W'(1);
                index_nxt  = '0;
                show_nxt   = '0;
                state_nxt  = SHOW_ON;
            end

            SHOW_ON: begin
                if (show_done) begin
                    show_nxt  = '0;
                    state_nxt = SHOW_OFF;
                end else begin
                    show_nxt = show_cnt + SHW_W'(1);
                end
            end

            SHOW_OFF: begin
                if (show_done) begin
                    show_nxt = '0;
                    if (at_last) begin
                        index_nxt = '0;
                        timer_nxt = '0;
                        state_nxt = INPUT;
                    end else begin
                        index_nxt = index + LEN_W'(1);
                        state_nxt = SHOW_ON;
                    end
                end else begin
                    show_nxt = show_cnt + SHW_W'(1);
                end
            end

            INPUT: begin
                if (btn_edge) begin
                    if (!press_ok) begin
                        state_nxt = OVER;
                    end else if (!at_last) begin
                        index_nxt = index + LEN_W'(1);
                        timer_nxt = '0;
                    end else begin
                        score_nxt = score + LEN_W'(1);
                        state_nxt = (length == LEN_W'(MAX_LEN)) ? WIN : EXTEND;
                    end
                end else if (mode_q == TIMED) begin
                    if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        state_nxt = OVER;
                    end else begin
                        timer_nxt = timer + TMR_W'(1);
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // Best score is refreshed only as a game finishes, using the final score.
    always_comb begin
        high_nxt = high_score;
        if ((state == INPUT) && ((state_nxt == OVER) || (state_nxt == WIN)) &&
            (score_nxt > high_score)) begin
            high_nxt = score_nxt;
        end
    end

    // Game counters, latched mode, score registers and the input edge detectors.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            mode_q     <= CLASSIC;
            start_prev <= 1'b0;
            btn_prev   <= '0;
            length     <= '0;
            index      <= '0;
            timer      <= '0;
            show_cnt   <= '0;
            score      <= '0;
            high_score <= '0;
        end else begin
            mode_q     <= mode_nxt;
            start_prev <= start;
            btn_prev   <= btn;
            length     <= length_nxt;
            index      <= index_nxt;
            timer      <= timer_nxt;
            show_cnt   <= show_nxt;
            score      <= score_nxt;
            high_score <= high_nxt;
        end
    end

    // Pattern memory: one new random symbol appended per round; contents need no reset.
    always_ff @(posedge clock) begin
        if (pat_we) begin
            pattern[length[ADDR_W-1:0]] <= lfsr_sym;
        end
    end

    // Outputs decoded from the current state; INPUT echoes last cycle's buttons.
    always_comb begin
        led    = '0;
        active = 1'b0;
        over   = 1'b0;
        win    = 1'b0;
        case (state)
            EXTEND:   active = 1'b1;
            SHOW_ON: begin
                active = 1'b1;
                led    = N_BTN'(1) << show_sym;
            end
            SHOW_OFF: active = 1'b1;
            INPUT: begin
                active = 1'b1;
                led    = btn_prev;
            end
            OVER:     over = 1'b1;
            WIN:      win  = 1'b1;
            default:  led  = '0;
        endcase
    end

endmodule

// File: tb/tb_memory_game_engine.sv
// Scoreboard bench for memory_game_engine with a short show phase and a 3-round game.
module tb_memory_game_engine;

    localparam int          N_BTN   = 8;
    localparam int          MAX_LEN = 3;
    localparam int          SHOW    = 4;
    localparam int          TMO     = 10;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic             clock = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       mode  = 2'd0;
    logic [N_BTN-1:0] btn   = '0;
    logic [N_BTN-1:0] led;
    logic             active;
    logic             over;
    logic             win;
    logic [1:0]       score;
    logic [1:0]       high_score;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference LFSR, expected LED events and expected end-of-game results.
    logic [15:0]      model_lfsr;
    logic [N_BTN-1:0] exp_led_q [$];
    logic [5:0]       exp_res_q [$];
    logic [2:0]       pat [MAX_LEN];
    int               plen;

    logic [N_BTN-1:0] led_prev  = '0;
    logic             over_prev = 1'b0;
    logic             win_prev  = 1'b0;

    always #5 clock = ~clock;

    memory_game_engine #(
        .N_BTN          (N_BTN),
        .MAX_LEN        (MAX_LEN),
        .SHOW_CYCLES    (SHOW),
        .TIMEOUT_CYCLES (TMO),
        .LFSR_SEED      (SEED)
    ) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .btn        (btn),
        .led        (led),
        .active     (active),
        .over       (over),
        .win        (win),
        .score      (score),
        .high_score (high_score)
    );

    function automatic logic [15:0] lfsrNext(input logic [15:0] s);
        logic [15:0] shifted;
        shifted = {1'b0, s[15:1]};
        if (s[0]) shifted = shifted ^ 16'b1011_0100_0000_0000;
        return shifted;
    endfunction

    function automatic logic [N_BTN-1:0] oneHot(input logic [2:0] sym);
        logic [N_BTN-1:0] v;
        v = '0;
        v[sym] = 1'b1;
        return v;
    endfunction

    // Reference LFSR runs in lockstep with the design from the same reset.
    always @(posedge clock) begin
        if (!rst_n) model_lfsr <= SEED;
        else        model_lfsr <= lfsrNext(model_lfsr);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: every fresh LED lighting and every game ending is checked against the queues.
    always @(negedge clock) begin
        if (led != '0 && led_prev == '0) begin
            if (exp_led_q.size() == 0) begin
                checkOutput("led_unexpected", 32'(led), 32'h0);
            end else begin
                checkOutput("led_event", 32'(led), 32'(exp_led_q.pop_front()));
            end
        end
        if ((over && !over_prev) || (win && !win_prev)) begin
            if (exp_res_q.size() == 0) begin
                checkOutput("result_unexpected", {26'h0, over, win, score, high_score}, 32'h0);
            end else begin
                checkOutput("game_result", {26'h0, over, win, score, high_score},
                            32'(exp_res_q.pop_front()));
            end
            checkOutput("led_at_end", 32'(led), 32'h0);
        end
        led_prev  <= led;
        over_prev <= over;
        win_prev  <= win;
    end

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // One-cycle button pulse; returns just after the edge that sampled it.
    task automatic applyStimulus(input logic [N_BTN-1:0] b);
        btn = b;
        waitCycles(1);
        btn = '0;
    endtask

    // Called in the EXTEND cycle: records the new symbol, expects the playback, waits for INPUT.
    task automatic extendRound();
        checkOutput("score_at_extend", 32'(score), 32'(plen));
        pat[plen] = model_lfsr[2:0];
        plen++;
        for (int i = 0; i < plen; i++) exp_led_q.push_back(oneHot(pat[i]));
        waitCycles(1 + 2 * SHOW * plen);
    endtask

    task automatic startGame(input logic [1:0] m);
        mode  = m;
        start = 1'b1;
        waitCycles(1);
        start = 1'b0;
        plen  = 0;
        extendRound();
    endtask

    initial begin
        logic [2:0] wrong_sym;

        waitCycles(3);
        checkOutput("reset_led", 32'(led), 32'h0);
        checkOutput("reset_active", 32'(active), 32'h0);
        checkOutput("reset_over", 32'(over), 32'h0);
        checkOutput("reset_win", 32'(win), 32'h0);
        checkOutput("reset_score", 32'(score), 32'h0);
        checkOutput("reset_high", 32'(high_score), 32'h0);
        rst_n = 1'b1;

        // Classic game played perfectly to a win.
        startGame(2'd0);
        for (int round = 1; round <= MAX_LEN; round++) begin
            for (int i = 0; i < plen; i++) begin
                if (i < plen - 1) exp_led_q.push_back(oneHot(pat[i]));
                else if (round == MAX_LEN) exp_res_q.push_back({1'b0, 1'b1, 2'd3, 2'd3});
                applyStimulus(oneHot(pat[i]));
                if (i < plen - 1) waitCycles(1);
            end
            if (round < MAX_LEN) extendRound();
        end
        checkOutput("classic_win", 32'(win), 32'h1);
        checkOutput("classic_score", 32'(score), 32'h3);
        checkOutput("classic_high", 32'(high_score), 32'h3);
        checkOutput("classic_led", 32'(led), 32'h0);

        // Reverse game: second round pressed in forward order.
        startGame(2'd2);
        applyStimulus(oneHot(pat[0]));
        extendRound();
        wrong_sym = (pat[0] != pat[1]) ? pat[0] : pat[1] + 3'd1;
        exp_res_q.push_back({1'b1, 1'b0, 2'd1, 2'd3});
        applyStimulus(oneHot(wrong_sym));
        checkOutput("reverse_over", 32'(over), 32'h1);
        checkOutput("reverse_score", 32'(score), 32'h1);
        checkOutput("reverse_high_kept", 32'(high_score), 32'h3);

        // Timed game: no presses at all.
        startGame(2'd1);
        waitCycles(TMO - 1);
        checkOutput("timed_still_input", 32'(active), 32'h1);
        checkOutput("timed_not_over", 32'(over), 32'h0);
        exp_res_q.push_back({1'b1, 1'b0, 2'd0, 2'd3});
        waitCycles(1);
        checkOutput("timed_timeout", 32'(over), 32'h1);

        // Mode 3 plays as classic; a start pulse and mode change mid-playback are ignored.
        mode  = 2'd3;
        start = 1'b1;
        waitCycles(1);
        start = 1'b0;
        plen  = 0;
        checkOutput("score_cleared", 32'(score), 32'h0);
        pat[0] = model_lfsr[2:0];
        plen   = 1;
        exp_led_q.push_back(oneHot(pat[0]));
        waitCycles(1);
        start = 1'b1;
        mode  = 2'd1;
        waitCycles(1);
        start = 1'b0;
        checkOutput("start_ignored_active", 32'(active), 32'h1);
        checkOutput("start_ignored_led", 32'(led), 32'(oneHot(pat[0])));
        waitCycles(2 * SHOW - 1);
        waitCycles(TMO + 2);
        checkOutput("classic_no_timeout", 32'(active), 32'h1);
        checkOutput("classic_no_over", 32'(over), 32'h0);
        exp_res_q.push_back({1'b1, 1'b0, 2'd0, 2'd3});
        applyStimulus(8'b0000_0011);
        checkOutput("two_buttons_over", 32'(over), 32'h1);

        // Reset in the middle of a playback.
        mode  = 2'd0;
        start = 1'b1;
        waitCycles(1);
        start = 1'b0;
        exp_led_q.push_back(oneHot(model_lfsr[2:0]));
        waitCycles(2);
        rst_n = 1'b0;
        waitCycles(1);
        checkOutput("midreset_led", 32'(led), 32'h0);
        checkOutput("midreset_active", 32'(active), 32'h0);
        checkOutput("midreset_over", 32'(over), 32'h0);
        checkOutput("midreset_win", 32'(win), 32'h0);
        checkOutput("midreset_score", 32'(score), 32'h0);
        checkOutput("midreset_high", 32'(high_score), 32'h0);
        rst_n = 1'b1;
        waitCycles(2);
        checkOutput("led_queue_drained", 32'(exp_led_q.size()), 32'h0);
        checkOutput("result_queue_drained", 32'(exp_res_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog so the run always ends even if the design stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/memory_game_engine.md
MEMORY_GAME_ENGINE -- requirements
Module: memory_game_engine

Interface
REQ-001 SHALL have parameter N_BTN, default 8: number of buttons/LEDs, power of two, 2..16.
REQ-002 SHALL have parameter MAX_LEN, default 16: pattern length at which the game is won, 1..64.
REQ-003 SHALL have parameter SHOW_CYCLES, default 1000: cycles per LED on-phase and per off-phase during playback.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 5000: timed-mode inactivity limit in INPUT.
REQ-005 SHALL have parameter LFSR_SEED, default 16'hACE1: nonzero LFSR reset value.
REQ-006 SHALL have port clock, input, 1: system clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-008 SHALL have port start, input, 1: start/play-again level, edge-detected internally.
REQ-009 SHALL have port mode, input, 2: 0 classic, 1 timed, 2 reverse, 3 treated as classic.
REQ-010 SHALL have port btn, input, N_BTN: player buttons, levels, pre-synchronised.
REQ-011 SHALL have port led, output, N_BTN: pattern playback / press echo.
REQ-012 SHALL have port active, output, 1: high in EXTEND, SHOW_ON, SHOW_OFF, INPUT.
REQ-013 SHALL have port over, output, 1: high in OVER.
REQ-014 SHALL have port win, output, 1: high in WIN.
REQ-015 SHALL have port score, output, $clog2(MAX_LEN+1): rounds completed in current/last game.
REQ-016 SHALL have port high_score, output, $clog2(MAX_LEN+1): best score since reset.

Function
REQ-017 States SHALL be IDLE, EXTEND, SHOW_ON, SHOW_OFF, INPUT, OVER, WIN.
REQ-018 Start edge = start high with previous-cycle start low; button edge = any bit of btn rising vs previous-cycle btn.
REQ-019 Start edge in IDLE, OVER or WIN SHALL latch mode, clear length and score, go to EXTEND next cycle; start edges elsewhere ignored; mode changes mid-game ignored.
REQ-020 EXTEND (one cycle) SHALL append lfsr[$clog2(N_BTN)-1:0] at position length, increment length, clear index, go to SHOW_ON.
REQ-021 LFSR SHALL advance every cycle regardless of state.
REQ-022 SHOW_ON SHALL drive led one-hot of pattern[index] for exactly SHOW_CYCLES cycles, then SHOW_OFF with led=0 for SHOW_CYCLES cycles.
REQ-023 Leaving SHOW_OFF: if index==length-1 go INPUT with index=0 and timer=0, else index+1 and SHOW_ON.
REQ-024 Expected symbol in INPUT SHALL be pattern[index] (classic/timed) or pattern[length-1-index] (reverse).
REQ-025 In INPUT, led SHALL equal registered btn (one-cycle echo).
REQ-026 Button edge with exactly one btn bit high equal to expected: correct; otherwise (wrong bit, multiple bits high) wrong -> OVER next cycle.
REQ-027 Correct press with index<length-1 SHALL increment index and clear timer; with index==length-1 SHALL increment score, then WIN if length==MAX_LEN, else EXTEND.
REQ-028 Timed mode: timer SHALL count every INPUT cycle without a button edge; reaching TIMEOUT_CYCLES-1 -> OVER; button edge in same cycle takes priority.
REQ-029 Classic/reverse modes SHALL have no timeout.
REQ-030 On entry to OVER or WIN, high_score SHALL load score-after-update if greater; high_score persists across games.
REQ-031 led SHALL be 0 in IDLE, EXTEND, OVER, WIN; score holds in OVER/WIN until next start edge.

Reset
REQ-032 rst_n low at a clock edge SHALL force IDLE, led=0, active=over=win=0, score=high_score=0, length=index=timer=0, LFSR=LFSR_SEED, edge-detect registers=0, from any state including mid-playback.

Structure
REQ-033 Package memory_game_pkg SHALL hold the state enum and mode enum (CLASSIC, TIMED, REVERSE).
REQ-034 Sub-module game_lfsr SHALL implement a 16-bit Galois LFSR, taps 16,14,13,11, synchronous seed load on reset.
REQ-035 Pattern storage SHALL be MAX_LEN x $clog2(N_BTN) registers inside memory_game_engine.

Verification (SHOW_CYCLES=4, TIMEOUT_CYCLES=10, MAX_LEN=3)
REQ-036 Classic: start pulse, mirror every playback correctly -> score 1,2,3, win=1, high_score=3, led 0.
REQ-037 Reverse: length-2 round, press pattern in forward order where it differs -> over=1, score=1.
REQ-038 Timed: reach INPUT, no press for 10 cycles -> over=1 on that edge; same in classic -> stays INPUT.
REQ-039 Two btn bits rising together in INPUT -> over=1; start during SHOW_ON -> ignored, playback continues.
REQ-040 Reset asserted mid SHOW_ON -> next cycle IDLE, all outputs 0; game after OVER with lower score -> high_score unchanged.
